// File: rtl/deco_pkg.sv
// Shared types for the Gray-code display sequencer.
// FSM state encoding, operand/result widths and the Gray decode helper.
package deco_pkg;

   localparam int GRAY_W = 4;
   localparam int BCD_W  = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_CONVERT,
      ST_WAIT,
      ST_UPDATE
   } state_t;

   // MSB passes through; each lower bit folds in the bit above it.
   function automatic logic [GRAY_W-1:0] gray_to_bin(
      input logic [GRAY_W-1:0] g
   );
      logic [GRAY_W-1:0] b;
      b[GRAY_W-1] = g[GRAY_W-1];
      for (int i = GRAY_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/module_refresh_tick.sv
// Free-running modulo-PERIOD counter with a one-cycle tick on wrap.
// Ports: clk_i, rst_i (async, active-low), tick_o (high while count = PERIOD-1).
module module_refresh_tick #(
   parameter int PERIOD = 2
)(
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick_o = (cnt == LAST);

endmodule

// File: rtl/module_deco_sequencer.sv
// Samples a Gray-code input, drives an external binary-to-BCD converter and
// scans the held two-digit result. Ports: clk_i, rst_i (async active-low),
// gray_code_i, conv_* handshake, bin_code_o, bcd_o, digit_sel_o, blank_o,
// busy_o, error_o (sticky converter timeout).
module module_deco_sequencer
   import deco_pkg::*;
#(
   parameter int INPUT_REFRESH   = 2700000,
   parameter int DISPLAY_REFRESH = 27000,
   parameter int CONV_TIMEOUT    = 64
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [GRAY_W-1:0] gray_code_i,
   output logic              conv_start_o,
   output logic [GRAY_W-1:0] conv_bin_o,
   input  logic              conv_done_i,
   input  logic [BCD_W-1:0]  conv_bcd_i,
   output logic [GRAY_W-1:0] bin_code_o,
   output logic [BCD_W-1:0]  bcd_o,
   output logic              digit_sel_o,
   output logic              blank_o,
   output logic              busy_o,
   output logic              error_o
);

   localparam int TW = (CONV_TIMEOUT > 1) ? $clog2(CONV_TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(CONV_TIMEOUT - 1);

   logic [GRAY_W-1:0] g_meta;
   logic [GRAY_W-1:0] g_sync;
   logic              tick_in;
   logic              tick_disp;
   state_t            state;
   state_t            state_nx;
   logic              pending;
   logic              valid;
   logic [TW-1:0]     wait_cnt;
   logic [GRAY_W-1:0] sample_bin;
   logic              same_code;
   logic              timeout;

   module_refresh_tick #(
      .PERIOD (INPUT_REFRESH)
   ) u_in_tick (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .tick_o (tick_in)
   );

   module_refresh_tick #(
      .PERIOD (DISPLAY_REFRESH)
   ) u_disp_tick (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .tick_o (tick_disp)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         g_meta <= '0;
         g_sync <= '0;
      end else begin
         g_meta <= gray_code_i;
         g_sync <= g_meta;
      end
   end

   assign sample_bin = gray_to_bin(g_sync);
   assign same_code  = valid && (sample_bin == bin_code_o);
   assign timeout    = (state == ST_WAIT) && !conv_done_i
                       && (wait_cnt == TO_LAST);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: begin
            if (tick_in || pending) begin
               state_nx = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            state_nx = same_code ? ST_IDLE : ST_CONVERT;
         end
         ST_CONVERT: begin
            state_nx = ST_WAIT;
         end
         ST_WAIT: begin
            if (conv_done_i) begin
               state_nx = ST_UPDATE;
            end else if (timeout) begin
               state_nx = ST_IDLE;
            end
         end
         ST_UPDATE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      conv_start_o = (state == ST_CONVERT);
      busy_o       = (state != ST_IDLE);
      blank_o      = digit_sel_o
                     && (bcd_o[BCD_W-1:BCD_W/2] == '0);
   end

   // In IDLE any tick is consumed by the transition itself, so pending
   // only ever collects a tick that lands while a cycle is in progress.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         conv_bin_o  <= '0;
         bin_code_o  <= '0;
         bcd_o       <= '0;
         valid       <= 1'b0;
         error_o     <= 1'b0;
         pending     <= 1'b0;
         wait_cnt    <= '0;
         digit_sel_o <= 1'b0;
      end else begin
         if (state == ST_IDLE) begin
            pending <= 1'b0;
         end else if (tick_in) begin
            pending <= 1'b1;
         end

         if (state == ST_SAMPLE) begin
            conv_bin_o <= sample_bin;
         end

         if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + TW'(1);
         end else begin
            wait_cnt <= '0;
         end

         if ((state == ST_WAIT) && conv_done_i) begin
            bcd_o      <= conv_bcd_i;
            bin_code_o <= conv_bin_o;
            valid      <= 1'b1;
         end

         if (timeout) begin
            error_o <= 1'b1;
            valid   <= 1'b0;
         end

         if (tick_disp) begin
            digit_sel_o <= ~digit_sel_o;
         end
      end
   end

endmodule

// File: tb/tb_module_deco_sequencer.sv
// Self-checking bench for module_deco_sequencer with a behavioural
// converter of programmable latency and an arithmetic reference model.
module tb_module_deco_sequencer;

   localparam int IR = 8;
   localparam int DR = 4;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] gray = 4'h0;
   logic       conv_start;
   logic [3:0] conv_bin;
   logic       conv_done;
   logic [7:0] conv_bcd;
   logic [3:0] bin_code;
   logic [7:0] bcd;
   logic       digit_sel;
   logic       blank;
   logic       busy;
   logic       error;

   int n_checks = 0;
   int n_fail = 0;

   bit         conv_en = 1'b1;
   int         conv_lat = 5;
   logic       auto_done = 1'b0;
   logic [7:0] auto_bcd = 8'h00;
   logic       man_done = 1'b0;
   logic [7:0] man_bcd = 8'h00;
   int         n_start = 0;

   logic [3:0] exp_bin = 4'h0;
   logic [7:0] exp_bcd = 8'h00;

   always #5 clk = ~clk;

   assign conv_done = auto_done | man_done;
   assign conv_bcd  = man_done ? man_bcd : auto_bcd;

   module_deco_sequencer #(
      .INPUT_REFRESH   (IR),
      .DISPLAY_REFRESH (DR),
      .CONV_TIMEOUT    (TO)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_n),
      .gray_code_i  (gray),
      .conv_start_o (conv_start),
      .conv_bin_o   (conv_bin),
      .conv_done_i  (conv_done),
      .conv_bcd_i   (conv_bcd),
      .bin_code_o   (bin_code),
      .bcd_o        (bcd),
      .digit_sel_o  (digit_sel),
      .blank_o      (blank),
      .busy_o       (busy),
      .error_o      (error)
   );

   // Reference: binary value is the XOR of all right-shifts of the code.
   function automatic logic [3:0] m_bin(input logic [3:0] g);
      return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
   endfunction

   function automatic logic [7:0] m_bcd(input logic [3:0] b);
      int t;
      int u;
      t = int'(b) / 10;
      u = int'(b) % 10;
      return {4'(t), 4'(u)};
   endfunction

   // Converter: done pulses conv_lat cycles after the start cycle.
   initial begin : conv_model
      int cnt;
      logic [3:0] op;
      cnt = 0;
      op = 4'h0;
      forever begin
         @(posedge clk);
         #1;
         auto_done = 1'b0;
         if (conv_start === 1'b1) begin
            n_start++;
            if (conv_en) begin
               cnt = conv_lat;
               op = conv_bin;
            end
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               auto_done = 1'b1;
               auto_bcd = m_bcd(op);
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_start(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (conv_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pick_new(output logic [3:0] g);
      do begin
         g = 4'($urandom_range(0, 15));
      end while (m_bin(g) == exp_bin);
   endtask

   task automatic test_reset();
      logic [20:0] obs;
      logic d0;
      rst_n = 1'b0;
      gray = 4'b1101;
      @(negedge clk);
      d0 = digit_sel;
      repeat (3 * DR) @(negedge clk);
      obs = {conv_start, conv_bin, bin_code, bcd,
             digit_sel, blank, busy, error};
      n_checks++;
      if (obs !== 21'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h want 0", obs);
      end
      n_checks++;
      if (digit_sel !== d0) begin
         n_fail++;
         $display("FAIL reset_scan_held: got %b want %b", digit_sel, d0);
      end
   endtask

   task automatic test_first_conv();
      bit ok;
      int base;
      int k;
      logic [3:0] eb;
      logic [7:0] ec;
      base = n_start;
      eb = m_bin(gray);
      ec = m_bcd(eb);
      rst_n = 1'b1;
      wait_start(30, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL first_start: no start pulse");
      end
      n_checks++;
      if (conv_bin !== eb) begin
         n_fail++;
         $display("FAIL first_conv_bin: got %h want %h", conv_bin, eb);
      end
      k = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         k++;
         if (bcd === ec && bin_code === eb) break;
      end
      n_checks++;
      if (k != conv_lat + 1) begin
         n_fail++;
         $display("FAIL first_latency: got %0d want %0d", k, conv_lat + 1);
      end
      wait_idle(10, ok);
      n_checks++;
      if (bcd !== ec || bin_code !== eb) begin
         n_fail++;
         $display("FAIL first_result: got %h/%h want %h/%h",
                  bcd, bin_code, ec, eb);
      end
      n_checks++;
      if (n_start - base != 1) begin
         n_fail++;
         $display("FAIL first_one_start: got %0d want 1", n_start - base);
      end
      exp_bin = eb;
      exp_bcd = ec;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (digit_sel === 1'b1) break;
      end
      n_checks++;
      if (digit_sel !== 1'b1 || blank !== 1'b1) begin
         n_fail++;
         $display("FAIL first_blank_tens: got sel %b blank %b want 1 1",
                  digit_sel, blank);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (digit_sel === 1'b0) break;
      end
      n_checks++;
      if (digit_sel !== 1'b0 || blank !== 1'b0) begin
         n_fail++;
         $display("FAIL first_blank_units: got sel %b blank %b want 0 0",
                  digit_sel, blank);
      end
   endtask

   task automatic test_display();
      bit ok;
      int t0;
      int t1;
      int cyc;
      logic cur;
      gray = 4'b1111;
      wait_start(30, ok);
      wait_idle(30, ok);
      exp_bin = m_bin(gray);
      exp_bcd = m_bcd(exp_bin);
      n_checks++;
      if (bcd !== exp_bcd || bin_code !== exp_bin) begin
         n_fail++;
         $display("FAIL disp_result: got %h/%h want %h/%h",
                  bcd, bin_code, exp_bcd, exp_bin);
      end
      cyc = 0;
      t0 = -1;
      t1 = -1;
      cur = digit_sel;
      for (int i = 0; i < 20 && t1 < 0; i++) begin
         @(negedge clk);
         cyc++;
         n_checks++;
         if (blank !== 1'b0) begin
            n_fail++;
            $display("FAIL disp_no_blank: got %b want 0 (sel %b)",
                     blank, digit_sel);
         end
         if (digit_sel !== cur) begin
            cur = digit_sel;
            if (t0 < 0) t0 = cyc;
            else t1 = cyc;
         end
      end
      n_checks++;
      if (t1 - t0 != DR) begin
         n_fail++;
         $display("FAIL disp_period: got %0d want %0d", t1 - t0, DR);
      end
   endtask

   task automatic test_no_reconvert();
      int base;
      bit saw_busy;
      base = n_start;
      saw_busy = 1'b0;
      repeat (3 * IR + 4) begin
         @(negedge clk);
         if (busy === 1'b1) saw_busy = 1'b1;
      end
      n_checks++;
      if (n_start != base) begin
         n_fail++;
         $display("FAIL noconv_starts: got %0d want 0", n_start - base);
      end
      n_checks++;
      if (saw_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL noconv_sampled: got %b want 1", saw_busy);
      end
      n_checks++;
      if (bcd !== exp_bcd) begin
         n_fail++;
         $display("FAIL noconv_bcd: got %h want %h", bcd, exp_bcd);
      end
   endtask

   task automatic test_random();
      bit ok;
      int k;
      logic [3:0] g;
      logic [3:0] eb;
      logic [7:0] ec;
      for (int it = 0; it < 6; it++) begin
         pick_new(g);
         conv_lat = $urandom_range(1, 10);
         eb = m_bin(g);
         ec = m_bcd(eb);
         gray = g;
         wait_start(30, ok);
         n_checks++;
         if (!ok || conv_bin !== eb) begin
            n_fail++;
            $display("FAIL rand_start[%0d]: got ok %b bin %h want 1 %h",
                     it, ok, conv_bin, eb);
         end
         k = 0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            k++;
            if (bcd === ec && bin_code === eb) break;
         end
         n_checks++;
         if (k != conv_lat + 1) begin
            n_fail++;
            $display("FAIL rand_latency[%0d]: got %0d want %0d",
                     it, k, conv_lat + 1);
         end
         wait_idle(10, ok);
         n_checks++;
         if (!ok || bcd !== ec) begin
            n_fail++;
            $display("FAIL rand_idle[%0d]: got ok %b bcd %h want 1 %h",
                     it, ok, bcd, ec);
         end
         exp_bin = eb;
         exp_bcd = ec;
      end
      conv_lat = 5;
   endtask

   task automatic test_long_latency();
      bit ok;
      int base;
      logic [3:0] a;
      logic [3:0] b;
      conv_lat = 12;
      base = n_start;
      pick_new(a);
      do begin
         b = 4'($urandom_range(0, 15));
      end while (m_bin(b) == m_bin(a));
      gray = a;
      wait_start(30, ok);
      repeat (2) @(negedge clk);
      gray = b;
      repeat (6) @(negedge clk);
      n_checks++;
      if (conv_bin !== m_bin(a) || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL long_bin_stable: got %h busy %b want %h 1",
                  conv_bin, busy, m_bin(a));
      end
      repeat (60) @(negedge clk);
      n_checks++;
      if (n_start - base != 2) begin
         n_fail++;
         $display("FAIL long_starts: got %0d want 2", n_start - base);
      end
      exp_bin = m_bin(b);
      exp_bcd = m_bcd(exp_bin);
      n_checks++;
      if (bin_code !== exp_bin || bcd !== exp_bcd) begin
         n_fail++;
         $display("FAIL long_result: got %h/%h want %h/%h",
                  bin_code, bcd, exp_bin, exp_bcd);
      end
      conv_lat = 5;
   endtask

   task automatic test_timeout();
      bit ok;
      int k;
      logic [3:0] g;
      conv_en = 1'b0;
      pick_new(g);
      gray = g;
      wait_start(30, ok);
      k = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         k++;
         if (error === 1'b1) break;
      end
      n_checks++;
      if (k != TO + 1) begin
         n_fail++;
         $display("FAIL timeout_cycles: got %0d want %0d", k, TO + 1);
      end
      n_checks++;
      if (bcd !== exp_bcd || bin_code !== exp_bin) begin
         n_fail++;
         $display("FAIL timeout_held: got %h/%h want %h/%h",
                  bcd, bin_code, exp_bcd, exp_bin);
      end
      conv_en = 1'b1;
      wait_start(30, ok);
      n_checks++;
      if (!ok || conv_bin !== m_bin(g)) begin
         n_fail++;
         $display("FAIL timeout_retry: got ok %b bin %h want 1 %h",
                  ok, conv_bin, m_bin(g));
      end
      wait_idle(30, ok);
      exp_bin = m_bin(g);
      exp_bcd = m_bcd(exp_bin);
      n_checks++;
      if (bcd !== exp_bcd || error !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_recover: got %h err %b want %h 1",
                  bcd, error, exp_bcd);
      end
   endtask

   task automatic test_reset_mid_wait();
      bit ok;
      int base;
      logic [3:0] g;
      logic [20:0] obs;
      conv_en = 1'b0;
      pick_new(g);
      gray = g;
      wait_start(30, ok);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      obs = {conv_start, conv_bin, bin_code, bcd,
             digit_sel, blank, busy, error};
      n_checks++;
      if (obs !== 21'h0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got %h want 0", obs);
      end
      gray = 4'h0;
      conv_en = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      base = n_start;
      repeat (2) @(negedge clk);
      man_bcd = 8'h55;
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bcd !== 8'h00 || bin_code !== 4'h0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL late_done_ignored: got %h/%h err %b want 00/0 0",
                  bcd, bin_code, error);
      end
      exp_bin = 4'h0;
      exp_bcd = 8'h00;
      wait_start(30, ok);
      n_checks++;
      if (!ok || conv_bin !== m_bin(gray)) begin
         n_fail++;
         $display("FAIL forced_first: got ok %b bin %h want 1 %h",
                  ok, conv_bin, m_bin(gray));
      end
      wait_idle(30, ok);
      repeat (3 * IR) @(negedge clk);
      n_checks++;
      if (n_start - base != 1 || bcd !== m_bcd(m_bin(gray))) begin
         n_fail++;
         $display("FAIL forced_once: got %0d starts bcd %h want 1 %h",
                  n_start - base, bcd, m_bcd(m_bin(gray)));
      end
   endtask

   initial begin
      test_reset();
      test_first_conv();
      test_display();
      test_no_reconvert();
      test_random();
      test_long_latency();
      test_timeout();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/module_deco_sequencer.md
MODULE_DECO_SEQUENCER -- requirements
Module: module_deco_sequencer

Interface
REQ-001 SHALL have parameter INPUT_REFRESH, default 2700000: clk_i cycles per input sample tick (>=2).
REQ-002 SHALL have parameter DISPLAY_REFRESH, default 27000: clk_i cycles per digit-scan toggle (>=2).
REQ-003 SHALL have parameter CONV_TIMEOUT, default 64: max cycles spent waiting for conv_done_i.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port gray_code_i, input, 4: asynchronous user Gray code.
REQ-007 SHALL have port conv_start_o, output, 1: one-cycle start pulse to the binary-to-BCD converter.
REQ-008 SHALL have port conv_bin_o, output, 4: binary operand to the converter.
REQ-009 SHALL have port conv_done_i, input, 1: converter result valid, 1-cycle pulse.
REQ-010 SHALL have port conv_bcd_i, input, 8: converter result, {tens, units}.
REQ-011 SHALL have port bin_code_o, output, 4: last committed binary value.
REQ-012 SHALL have port bcd_o, output, 8: held display value.
REQ-013 SHALL have port digit_sel_o, output, 1: scanned digit, 0 = units, 1 = tens.
REQ-014 SHALL have port blank_o, output, 1: blank the current digit.
REQ-015 SHALL have port busy_o, output, 1: FSM not in IDLE.
REQ-016 SHALL have port error_o, output, 1: sticky converter-timeout flag.

Function
REQ-017 SHALL pass gray_code_i through a 2-flop synchronizer before use.
REQ-018 SHALL produce a 1-cycle sample tick when the input counter wraps, counting 0..INPUT_REFRESH-1.
REQ-019 SHALL implement FSM IDLE -> SAMPLE -> CONVERT -> WAIT -> UPDATE -> IDLE.
REQ-020 SHALL, in IDLE, go to SAMPLE on a tick or a set pending flag, clearing pending.
REQ-021 SHALL, in SAMPLE, register bin[3]=g[3], bin[i]=bin[i+1]^g[i] into conv_bin_o.
REQ-022 SHALL, in SAMPLE, return to IDLE when that value equals bin_code_o and the committed-valid flag is set; otherwise go to CONVERT.
REQ-023 SHALL assert conv_start_o for exactly the single CONVERT cycle; conv_bin_o SHALL stay stable from CONVERT until leaving WAIT.
REQ-024 SHALL, in WAIT, on conv_done_i latch conv_bcd_i into bcd_o and conv_bin_o into bin_code_o, set valid, and go to UPDATE.
REQ-025 SHALL, on CONV_TIMEOUT WAIT cycles without done, set error_o, clear valid, leave bcd_o and bin_code_o unchanged, and go to IDLE.
REQ-026 SHALL ignore conv_done_i outside WAIT.
REQ-027 SHALL make UPDATE one cycle; bcd_o and bin_code_o SHALL be visible on the cycle after the done cycle.
REQ-028 SHALL set pending on a tick outside IDLE; at most one tick is held, further ticks are dropped.
REQ-029 SHALL give a tick arriving in the same cycle as the IDLE->SAMPLE transition priority; it is consumed and does not set pending.
REQ-030 SHALL toggle digit_sel_o on each wrap of the display counter (0..DISPLAY_REFRESH-1), free-running and independent of the FSM.
REQ-031 SHALL assert blank_o when digit_sel_o=1 and bcd_o[7:4]=0; otherwise deassert it.
REQ-032 SHALL make the worst-case sample-to-display latency 3 + converter latency cycles.

Reset
REQ-033 SHALL, with rst_i low, immediately force FSM=IDLE, both counters=0, synchronizer=0, and pending, valid, error_o=0.
REQ-034 SHALL, with rst_i low, immediately force outputs conv_start_o=0, conv_bin_o=0, bin_code_o=0, bcd_o=8'h00, digit_sel_o=0, blank_o=0, busy_o=0.
REQ-035 SHALL abandon any in-flight conversion on reset mid-operation; a late conv_done_i after release is ignored.
REQ-036 SHALL force a conversion on the first sample after reset (valid=0).

Structure
REQ-037 SHALL place the FSM state enum, GRAY_W=4 and BCD_W=8 in shared package deco_pkg.
REQ-038 SHALL instantiate sub-module module_refresh_tick (parameter PERIOD, output tick_o) twice, for sample and display.

Verification (INPUT_REFRESH=8, DISPLAY_REFRESH=4, CONV_TIMEOUT=16, behavioural converter with 5-cycle latency)
REQ-039 SHALL cover: gray 4'b1101 after reset -> conv_bin_o=4'h9, one start pulse, bcd_o=8'h09, bin_code_o=4'h9, blank_o=1 on tens.
REQ-040 SHALL cover: gray 4'b1111 -> bcd_o=8'h10, blank_o=0 on both digits.
REQ-041 SHALL cover: gray unchanged across 3 ticks -> no further conv_start_o pulses.
REQ-042 SHALL cover: converter never responds -> error_o=1 after 16 WAIT cycles, bcd_o held; next tick retries the conversion.
REQ-043 SHALL cover: reset pulsed during WAIT, then a late conv_done_i -> all outputs 0, done ignored.
REQ-044 SHALL cover: converter latency 12 (> INPUT_REFRESH) -> exactly one pending conversion follows, no tick lost beyond one.
